// File: rtl/block_plot_scheduler_pkg.sv
// block_plot_scheduler_pkg: shared geometry, colour constants and FSM encoding for the block plot scheduler
package block_plot_scheduler_pkg;
    localparam int N_REQ = 3;
    localparam int BLOCK = 8;
    localparam int XW    = 9;
    localparam int YW    = 8;
    localparam int CW    = 3;
    localparam int H_RES = 320;
    localparam int V_RES = 240;
    localparam logic [CW-1:0] BLACK  = 3'b000;
    localparam logic [CW-1:0] RED    = 3'b100;
    localparam logic [CW-1:0] YELLOW = 3'b110;
    localparam logic [CW-1:0] WHITE  = 3'b111;
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_DRAW = 2'd1, S_DONE = 2'd2} state_t;
endpackage

// File: rtl/block_plot_scheduler_if.sv
// block_plot_scheduler_if: requester bundle in, shared VGA pixel-write port out
interface block_plot_scheduler_if;
    import block_plot_scheduler_pkg::*;
    logic [N_REQ-1:0]    req;
    logic [N_REQ*XW-1:0] req_x;
    logic [N_REQ*YW-1:0] req_y;
    logic [N_REQ*CW-1:0] req_colour;
    logic [N_REQ-1:0]    ack;
    logic                busy;
    logic [XW-1:0]       vga_x;
    logic [YW-1:0]       vga_y;
    logic [CW-1:0]       vga_colour;
    logic                vga_plot;
    modport master (output req, req_x, req_y, req_colour,
                    input  ack, busy, vga_x, vga_y, vga_colour, vga_plot);
    modport slave  (input  req, req_x, req_y, req_colour,
                    output ack, busy, vga_x, vga_y, vga_colour, vga_plot);
endinterface

// File: rtl/block_plot_scheduler_plot_rr_arbiter.sv
// plot_rr_arbiter: combinational round-robin pick starting just after the last granted requester
module plot_rr_arbiter #(
    parameter int N  = 3,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_last,
    output logic [N-1:0]  o_grant,
    output logic [IW-1:0] o_idx,
    output logic          o_valid
);
    logic [IW-1:0] w_c;
    // scan last+1, last+2, ... mod N and keep the first requester found
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        w_c     = '0;
        for (int k = 1; k <= N; k++) begin
            w_c = IW'((int'(i_last) + k) % N);
            if (!o_valid && i_req[w_c]) begin
                o_valid    = 1'b1;
                o_idx      = w_c;
                o_grant    = N'(1) << w_c;
            end
        end
    end
endmodule

// File: rtl/block_plot_scheduler.sv
// block_plot_scheduler: round-robin sharing of the VGA pixel port, drawing each grant as a BLOCK x BLOCK square
module block_plot_scheduler
    import block_plot_scheduler_pkg::*;
(
    input  logic                    i_clock,
    input  logic                    i_reset,
    block_plot_scheduler_if.slave   io_bus
);
    localparam int IW = $clog2(N_REQ);
    localparam int BW = $clog2(BLOCK);

    state_t            r_state, w_next;
    logic [IW-1:0]     r_last, w_idx;
    logic [N_REQ-1:0]  r_gnt, w_grant;
    logic              w_valid;
    logic [XW-1:0]     r_ox, w_x;
    logic [YW-1:0]     r_oy, w_y;
    logic [CW-1:0]     r_oc;
    logic [BW-1:0]     r_dx, r_dy;
    logic              w_last_px;

    plot_rr_arbiter #(.N(N_REQ)) u_arb (
        .i_req   (io_bus.req),
        .i_last  (r_last),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_valid (w_valid)
    );

    assign w_last_px = (r_dx == BW'(BLOCK - 1)) && (r_dy == BW'(BLOCK - 1));
    assign w_x       = r_ox + XW'(r_dx);
    assign w_y       = r_oy + YW'(r_dy);

    // state register
    always_ff @(posedge i_clock) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    // next state and outputs, all derived from registers so req never reaches the VGA port combinationally
    always_comb begin
        w_next            = r_state;
        io_bus.ack        = '0;
        io_bus.busy       = (r_state != S_IDLE);
        io_bus.vga_x      = w_x;
        io_bus.vga_y      = w_y;
        io_bus.vga_colour = r_oc;
        io_bus.vga_plot   = (r_state == S_DRAW) && (w_x < XW'(H_RES)) && (w_y < YW'(V_RES));
        w_next = (r_state == S_IDLE) ? (w_valid ? S_DRAW : S_IDLE) :
                 (r_state == S_DRAW) ? (w_last_px ? S_DONE : S_DRAW) : S_IDLE;
        io_bus.ack = (r_state == S_DONE) ? r_gnt : '0;
    end

    // grant latch and raster counter; dx/dy freeze on the last pixel so the port holds it afterwards
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_last <= IW'(N_REQ - 1);
            r_gnt  <= '0;
            r_ox   <= '0;
            r_oy   <= '0;
            r_oc   <= '0;
            r_dx   <= '0;
            r_dy   <= '0;
        end else if (r_state == S_IDLE && w_valid) begin
            r_last <= w_idx;
            r_gnt  <= w_grant;
            r_ox   <= io_bus.req_x[w_idx*XW +: XW];
            r_oy   <= io_bus.req_y[w_idx*YW +: YW];
            r_oc   <= io_bus.req_colour[w_idx*CW +: CW];
            r_dx   <= '0;
            r_dy   <= '0;
        end else if (r_state == S_DRAW && !w_last_px) begin
            r_dx   <= r_dx + BW'(1);
            r_dy   <= r_dy + BW'(r_dx == BW'(BLOCK - 1));
        end
    end
endmodule

// File: tb/tb_block_plot_scheduler.sv
// tb_block_plot_scheduler: directed scenarios for the round-robin block plot scheduler
module tb_block_plot_scheduler;
    import block_plot_scheduler_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   plots;

    block_plot_scheduler_if bus();

    block_plot_scheduler dut (
        .i_clock (clk),
        .i_reset (rst),
        .io_bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_origin(input int i, input int x, input int y, input logic [CW-1:0] c);
        bus.req_x[i*XW +: XW]      = XW'(x);
        bus.req_y[i*YW +: YW]      = YW'(y);
        bus.req_colour[i*CW +: CW] = c;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic burst(input string name, input int g, input int ox, input int oy, input logic [CW-1:0] col,
                         input logic [N_REQ-1:0] after_ack, input int chg_at, input int abort_at, output int np);
        logic [XW-1:0] ex;
        logic [YW-1:0] ey;
        logic          ep;
        np = 0;
        for (int p = 0; p < BLOCK*BLOCK; p++) begin
            tick();
            ex = XW'(ox + p % BLOCK);
            ey = YW'(oy + p / BLOCK);
            ep = (int'(ex) < H_RES) && (int'(ey) < V_RES);
            n_cmp++;
            if ({bus.vga_plot, bus.vga_x, bus.vga_y, bus.vga_colour, bus.ack, bus.busy} !== {ep, ex, ey, col, N_REQ'(0), 1'b1}) begin
                n_bad++;
                $display("FAIL %s pixel %0d: got plot=%b x=%0d y=%0d c=%b ack=%b busy=%b, want plot=%b x=%0d y=%0d c=%b ack=000 busy=1",
                         name, p, bus.vga_plot, bus.vga_x, bus.vga_y, bus.vga_colour, bus.ack, bus.busy, ep, ex, ey, col);
            end
            np += int'(bus.vga_plot);
            if (p == chg_at) begin
                bus.req[g] = 1'b0;
                bus.req_x[g*XW +: XW] = XW'(ox + 100);
            end
            if (p == abort_at) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                n_cmp++;
                if ({bus.vga_plot, bus.busy, bus.ack, bus.vga_x, bus.vga_y, bus.vga_colour} !== '0) begin
                    n_bad++;
                    $display("FAIL %s after reset: got plot=%b busy=%b ack=%b x=%0d y=%0d c=%b, want all zero",
                             name, bus.vga_plot, bus.busy, bus.ack, bus.vga_x, bus.vga_y, bus.vga_colour);
                end
                return;
            end
        end
        tick();
        n_cmp++;
        if ({bus.ack, bus.vga_plot, bus.busy, bus.vga_x, bus.vga_y} !== {N_REQ'(1) << g, 1'b0, 1'b1, XW'(ox + BLOCK - 1), YW'(oy + BLOCK - 1)}) begin
            n_bad++;
            $display("FAIL %s done: got ack=%b plot=%b busy=%b x=%0d y=%0d, want ack=%b plot=0 busy=1 x=%0d y=%0d",
                     name, bus.ack, bus.vga_plot, bus.busy, bus.vga_x, bus.vga_y, N_REQ'(1) << g, XW'(ox + BLOCK - 1), YW'(oy + BLOCK - 1));
        end
        bus.req = after_ack;
        tick();
        n_cmp++;
        if ({bus.ack, bus.vga_plot, bus.busy, bus.vga_x} !== {N_REQ'(0), 1'b0, 1'b0, XW'(ox + BLOCK - 1)}) begin
            n_bad++;
            $display("FAIL %s idle: got ack=%b plot=%b busy=%b x=%0d, want ack=000 plot=0 busy=0 x=%0d",
                     name, bus.ack, bus.vga_plot, bus.busy, bus.vga_x, XW'(ox + BLOCK - 1));
        end
    endtask

    task automatic test_reset();
        bus.req = '0;
        set_origin(0, 0, 0, BLACK);
        set_origin(1, 0, 0, BLACK);
        set_origin(2, 0, 0, BLACK);
        rst = 1'b1;
        tick();
        tick();
        n_cmp++;
        if ({bus.ack, bus.busy, bus.vga_plot, bus.vga_x, bus.vga_y, bus.vga_colour} !== '0) begin
            n_bad++;
            $display("FAIL reset: got ack=%b busy=%b plot=%b x=%0d y=%0d c=%b, want all zero",
                     bus.ack, bus.busy, bus.vga_plot, bus.vga_x, bus.vga_y, bus.vga_colour);
        end
        rst = 1'b0;
        tick();
        n_cmp++;
        if ({bus.busy, bus.vga_plot} !== 2'b00) begin
            n_bad++;
            $display("FAIL idle_no_req: got busy=%b plot=%b, want 0 0", bus.busy, bus.vga_plot);
        end
    endtask

    task automatic test_single();
        set_origin(0, 10, 20, YELLOW);
        bus.req = 3'b001;
        burst("single", 0, 10, 20, YELLOW, 3'b000, -1, -1, plots);
        n_cmp++;
        if (plots !== 64) begin
            n_bad++;
            $display("FAIL single_count: got %0d plots, want 64", plots);
        end
    endtask

    task automatic test_back_to_back();
        pulse_reset();
        set_origin(0, 40, 30, RED);
        set_origin(1, 80, 60, WHITE);
        bus.req = 3'b011;
        burst("b2b_r0", 0, 40, 30, RED, 3'b010, -1, -1, plots);
        burst("b2b_r1", 1, 80, 60, WHITE, 3'b000, -1, -1, plots);
    endtask

    task automatic test_round_robin();
        pulse_reset();
        set_origin(0, 0, 0, WHITE);
        set_origin(1, 100, 50, RED);
        set_origin(2, 200, 100, YELLOW);
        bus.req = 3'b111;
        burst("rr_0a", 0, 0, 0, WHITE, 3'b111, -1, -1, plots);
        burst("rr_1a", 1, 100, 50, RED, 3'b111, -1, -1, plots);
        burst("rr_2a", 2, 200, 100, YELLOW, 3'b111, -1, -1, plots);
        burst("rr_0b", 0, 0, 0, WHITE, 3'b111, -1, -1, plots);
        burst("rr_1b", 1, 100, 50, RED, 3'b000, -1, -1, plots);
    endtask

    task automatic test_clip();
        set_origin(0, 316, 236, WHITE);
        bus.req = 3'b001;
        burst("clip", 0, 316, 236, WHITE, 3'b000, -1, -1, plots);
        n_cmp++;
        if (plots !== 16) begin
            n_bad++;
            $display("FAIL clip_count: got %0d plots, want 16", plots);
        end
    endtask

    task automatic test_mid_reset();
        set_origin(1, 50, 60, RED);
        bus.req = 3'b010;
        burst("abort_r1", 1, 50, 60, RED, 3'b000, -1, 30, plots);
        set_origin(0, 20, 10, YELLOW);
        bus.req = 3'b011;
        burst("post_rst_r0", 0, 20, 10, YELLOW, 3'b010, -1, -1, plots);
        burst("post_rst_r1", 1, 50, 60, RED, 3'b000, -1, -1, plots);
    endtask

    task automatic test_drop_mid_draw();
        set_origin(0, 120, 90, WHITE);
        bus.req = 3'b001;
        burst("drop", 0, 120, 90, WHITE, 3'b000, 10, -1, plots);
        n_cmp++;
        if (plots !== 64) begin
            n_bad++;
            $display("FAIL drop_count: got %0d plots, want 64", plots);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++;
            if ({bus.ack, bus.busy, bus.vga_plot} !== 5'b0) begin
                n_bad++;
                $display("FAIL drop_quiet %0d: got ack=%b busy=%b plot=%b, want 000 0 0", i, bus.ack, bus.busy, bus.vga_plot);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_round_robin();
        test_clip();
        test_mid_reset();
        test_drop_mid_draw();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
